// File: rtl/hpu_pkg.sv
// Shared definitions for the destination-buffer control path: fill-FSM
// state encoding and the address widths seen by dst_buf.
package hpu_pkg;

  localparam int OUT_ADDR_W    = 6;
  localparam int STREAM_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OUT   = 2'd1,
    WAIT  = 2'd2,
    CLOSE = 2'd3
  } dst_state_t;

endpackage

// File: rtl/dst_stream_ctrl.sv
// Drain engine for a closed destination buffer: issues word fetches and
// turns the buffer's one-cycle read latency into an M_AXIS valid/last pair.
module dst_stream_ctrl
  import hpu_pkg::*;
#(
  parameter int STREAM_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     m_axis_tready,
  output logic                     stream_v,
  output logic [STREAM_ADDR_W-1:0] stream_a,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic                     idle_next
);

  localparam int CNT_W = STREAM_ADDR_W + 1;
  localparam logic [CNT_W-1:0]         LEN    = CNT_W'(STREAM_LEN);
  localparam logic [STREAM_ADDR_W-1:0] A_LAST = STREAM_ADDR_W'(STREAM_LEN - 1);

  logic [CNT_W-1:0]         pend;
  logic [CNT_W-1:0]         pend_nxt;
  logic [STREAM_ADDR_W-1:0] a_nxt;
  logic                     tvalid_nxt;
  logic                     tlast_nxt;

  // A fetch is allowed whenever the output word slot is empty or being consumed.
  assign stream_v = (pend != '0) && (!m_axis_tvalid || m_axis_tready);

  always_comb begin
    pend_nxt   = pend;
    a_nxt      = stream_a;
    tvalid_nxt = m_axis_tvalid;
    tlast_nxt  = m_axis_tlast;
    if (load) begin
      pend_nxt = LEN;
      a_nxt    = '0;
    end else if (stream_v) begin
      pend_nxt   = pend - 1'b1;
      a_nxt      = (stream_a == A_LAST) ? '0 : stream_a + 1'b1;
      tvalid_nxt = 1'b1;
      tlast_nxt  = (stream_a == A_LAST);
    end else if (m_axis_tvalid && m_axis_tready) begin
      tvalid_nxt = 1'b0;
      tlast_nxt  = 1'b0;
    end
  end

  // Lets the fill FSM close a buffer in the cycle right after the final handshake.
  assign idle_next = (pend_nxt == '0) && !tvalid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend          <= '0;
      stream_a      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      pend          <= pend_nxt;
      stream_a      <= a_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
    end
  end

endmodule

// File: rtl/dst_ctrl.sv
// Destination-buffer sequencer: fill FSM, ping-pong select and drain hand-off.
// Define DST_CTRL_PERF_EN to build the stall_cycles / word_cnt counters.
module dst_ctrl
  import hpu_pkg::*;
#(
  parameter int OUT_LEN    = 4,
  parameter int SEG_NUM    = 4,
  parameter int STREAM_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exe_fin,
  output logic                     exe_stall,
  output logic                     out_period,
  output logic [OUT_ADDR_W-1:0]    out_addr,
  output logic                     out_fin,
  output logic                     s_fin,
  output logic                     p,
  output logic                     stream_v,
  output logic [STREAM_ADDR_W-1:0] stream_a,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     proto_err,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              word_cnt
);

  localparam logic [OUT_ADDR_W-1:0] OUT_LAST = OUT_ADDR_W'(OUT_LEN - 1);
  localparam logic [7:0]            SEG_LAST = 8'(SEG_NUM - 1);

  dst_state_t            state;
  dst_state_t            state_nxt;
  logic [7:0]            seg_cnt;
  logic [7:0]            seg_nxt;
  logic [OUT_ADDR_W-1:0] addr_nxt;
  logic                  period_nxt;
  logic                  fin_nxt;
  logic                  sfin_nxt;
  logic                  stall_nxt;
  logic                  idle_next;
  logic                  busy;
  logic                  accept;

  assign busy   = (state == OUT) || (state == CLOSE) || exe_stall;
  assign accept = exe_fin && !busy;

  always_comb begin
    state_nxt  = state;
    seg_nxt    = seg_cnt;
    addr_nxt   = out_addr;
    period_nxt = 1'b0;
    fin_nxt    = 1'b0;
    sfin_nxt   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (accept) begin
          state_nxt  = OUT;
          period_nxt = 1'b1;
          addr_nxt   = '0;
          fin_nxt    = (OUT_LAST == '0);
        end
      end
      OUT: begin
        if (out_addr == OUT_LAST) begin
          addr_nxt = '0;
          if (seg_cnt == SEG_LAST) begin
            state_nxt = CLOSE;
            sfin_nxt  = idle_next;
          end else begin
            state_nxt = WAIT;
            seg_nxt   = seg_cnt + 1'b1;
          end
        end else begin
          period_nxt = 1'b1;
          addr_nxt   = out_addr + 1'b1;
          fin_nxt    = ((out_addr + 1'b1) == OUT_LAST);
        end
      end
      CLOSE: begin
        if (s_fin) begin
          state_nxt = WAIT;
          seg_nxt   = '0;
        end else begin
          sfin_nxt = idle_next;
        end
      end
      default: state_nxt = IDLE;
    endcase
    stall_nxt = (state_nxt == OUT) || (state_nxt == CLOSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seg_cnt    <= '0;
      out_addr   <= '0;
      out_period <= 1'b0;
      out_fin    <= 1'b0;
      s_fin      <= 1'b0;
      exe_stall  <= 1'b0;
      p          <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      seg_cnt    <= seg_nxt;
      out_addr   <= addr_nxt;
      out_period <= period_nxt;
      out_fin    <= fin_nxt;
      s_fin      <= sfin_nxt;
      exe_stall  <= stall_nxt;
      if (s_fin) p <= ~p;
      if (exe_fin && busy) proto_err <= 1'b1;
    end
  end

  // The closing s_fin edge both flips p and hands the buffer to the drain engine.
  dst_stream_ctrl #(
    .STREAM_LEN(STREAM_LEN)
  ) u_stream (
    .clk          (clk),
    .rst          (rst),
    .load         (s_fin),
    .m_axis_tready(m_axis_tready),
    .stream_v     (stream_v),
    .stream_a     (stream_a),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .idle_next    (idle_next)
  );

`ifdef DST_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      word_cnt     <= '0;
    end else begin
      if (exe_stall && (state == CLOSE)) stall_cycles <= stall_cycles + 1'b1;
      if (m_axis_tvalid && m_axis_tready) word_cnt <= word_cnt + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign word_cnt     = '0;
`endif

endmodule
